// File: rtl/matmul_sched_pkg.sv
// Shared types and job-descriptor layout for the matmul job scheduler.
// Descriptor fields are packed LSB-first in field_e order.
package matmul_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_CPL
    } state_e;

    typedef enum logic [3:0] {
        F_ID,
        F_ABASE,
        F_BBASE,
        F_CBASE,
        F_ASTRIDE,
        F_BSTRIDE,
        F_CSTRIDE,
        F_AROWS,
        F_ACOLS,
        F_BCOLS
    } field_e;

    localparam int unsigned CNT_W          = 32;
    localparam int unsigned NUM_ADDR_FLDS  = 3;
    localparam int unsigned NUM_DIM_FLDS   = 6;

    function automatic int unsigned fld_width(field_e f, int unsigned aw,
                                              int unsigned dw, int unsigned iw);
        case (f)
            F_ID:                        return iw;
            F_ABASE, F_BBASE, F_CBASE:   return aw;
            default:                     return dw;
        endcase
    endfunction

    function automatic int unsigned fld_offset(field_e f, int unsigned aw,
                                               int unsigned dw, int unsigned iw);
        case (f)
            F_ID:      return 0;
            F_ABASE:   return iw;
            F_BBASE:   return iw + aw;
            F_CBASE:   return iw + 2 * aw;
            F_ASTRIDE: return iw + 3 * aw;
            F_BSTRIDE: return iw + 3 * aw + dw;
            F_CSTRIDE: return iw + 3 * aw + 2 * dw;
            F_AROWS:   return iw + 3 * aw + 3 * dw;
            F_ACOLS:   return iw + 3 * aw + 4 * dw;
            default:   return iw + 3 * aw + 5 * dw;
        endcase
    endfunction

    function automatic int unsigned desc_width(int unsigned aw, int unsigned dw,
                                               int unsigned iw);
        return iw + NUM_ADDR_FLDS * aw + NUM_DIM_FLDS * dw;
    endfunction

    localparam int unsigned DESC_W_DEFAULT = desc_width(16, 16, 4);

endpackage

// File: rtl/matmul_sched_if.sv
// Host-side and engine-side signal bundle of the matmul job scheduler.
// slave = scheduler view, master = host/engine view.
interface matmul_sched_if #(
    parameter int MEM_AW   = 16,
    parameter int DIM_BITS = 16,
    parameter int DEPTH    = 4,
    parameter int ID_W     = 4
) ();
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [ID_W-1:0]              cmd_id;
    logic [MEM_AW-1:0]            cmd_abase;
    logic [MEM_AW-1:0]            cmd_bbase;
    logic [MEM_AW-1:0]            cmd_cbase;
    logic [DIM_BITS-1:0]          cmd_astride;
    logic [DIM_BITS-1:0]          cmd_bstride;
    logic [DIM_BITS-1:0]          cmd_cstride;
    logic [DIM_BITS-1:0]          cmd_arows;
    logic [DIM_BITS-1:0]          cmd_acols;
    logic [DIM_BITS-1:0]          cmd_bcols;

    logic                         eng_go;
    logic [MEM_AW-1:0]            eng_abase;
    logic [MEM_AW-1:0]            eng_bbase;
    logic [MEM_AW-1:0]            eng_cbase;
    logic [DIM_BITS-1:0]          eng_astride;
    logic [DIM_BITS-1:0]          eng_bstride;
    logic [DIM_BITS-1:0]          eng_cstride;
    logic [DIM_BITS-1:0]          eng_arows;
    logic [DIM_BITS-1:0]          eng_acols;
    logic [DIM_BITS-1:0]          eng_bcols;
    logic                         eng_ret;

    logic                         done_valid;
    logic                         done_ready;
    logic [ID_W-1:0]              done_id;
    logic                         done_skip;
    logic [31:0]                  done_cycles;

    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   fifo_level;

    modport slave (
        input  cmd_valid, cmd_id, cmd_abase, cmd_bbase, cmd_cbase,
               cmd_astride, cmd_bstride, cmd_cstride, cmd_arows, cmd_acols, cmd_bcols,
        output cmd_ready,
        output eng_go, eng_abase, eng_bbase, eng_cbase,
               eng_astride, eng_bstride, eng_cstride, eng_arows, eng_acols, eng_bcols,
        input  eng_ret,
        output done_valid, done_id, done_skip, done_cycles,
        input  done_ready,
        output busy, fifo_level
    );

    modport master (
        output cmd_valid, cmd_id, cmd_abase, cmd_bbase, cmd_cbase,
               cmd_astride, cmd_bstride, cmd_cstride, cmd_arows, cmd_acols, cmd_bcols,
        input  cmd_ready,
        input  eng_go, eng_abase, eng_bbase, eng_cbase,
               eng_astride, eng_bstride, eng_cstride, eng_arows, eng_acols, eng_bcols,
        output eng_ret,
        input  done_valid, done_id, done_skip, done_cycles,
        output done_ready,
        input  busy, fifo_level
    );
endinterface

// File: rtl/matmul_sched_fifo.sv
// Synchronous job FIFO with registered full/empty/level; push when full
// and pop when empty are ignored.
module matmul_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_din,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_dout,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH+1)-1:0]  o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [LW-1:0]    w_level_nxt;

    assign w_do_push   = i_push & ~r_full;
    assign w_do_pop    = i_pop & ~r_empty;
    assign w_level_nxt = r_level + LW'(w_do_push) - LW'(w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;
endmodule

// File: rtl/matmul_sched.sv
// Matmul job scheduler: queues job descriptors, launches them one at a time
// on the engine, times each run and returns a completion record.
module matmul_sched
    import matmul_sched_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int DIM_BITS = 16,
    parameter int DEPTH    = 4,
    parameter int ID_W     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    matmul_sched_if.slave bus
);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int DESC_W = int'(desc_width(MEM_AW, DIM_BITS, ID_W));

    localparam int W_ID  = int'(fld_width(F_ID, MEM_AW, DIM_BITS, ID_W));
    localparam int W_AD  = int'(fld_width(F_ABASE, MEM_AW, DIM_BITS, ID_W));
    localparam int W_DM  = int'(fld_width(F_AROWS, MEM_AW, DIM_BITS, ID_W));

    localparam int O_ID  = int'(fld_offset(F_ID,      MEM_AW, DIM_BITS, ID_W));
    localparam int O_AB  = int'(fld_offset(F_ABASE,   MEM_AW, DIM_BITS, ID_W));
    localparam int O_BB  = int'(fld_offset(F_BBASE,   MEM_AW, DIM_BITS, ID_W));
    localparam int O_CB  = int'(fld_offset(F_CBASE,   MEM_AW, DIM_BITS, ID_W));
    localparam int O_AS  = int'(fld_offset(F_ASTRIDE, MEM_AW, DIM_BITS, ID_W));
    localparam int O_BS  = int'(fld_offset(F_BSTRIDE, MEM_AW, DIM_BITS, ID_W));
    localparam int O_CS  = int'(fld_offset(F_CSTRIDE, MEM_AW, DIM_BITS, ID_W));
    localparam int O_AR  = int'(fld_offset(F_AROWS,   MEM_AW, DIM_BITS, ID_W));
    localparam int O_AC  = int'(fld_offset(F_ACOLS,   MEM_AW, DIM_BITS, ID_W));
    localparam int O_BC  = int'(fld_offset(F_BCOLS,   MEM_AW, DIM_BITS, ID_W));

    logic [DESC_W-1:0] w_din;
    logic [DESC_W-1:0] w_dout;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;
    logic              w_zero_dim;
    logic              w_ret_rise;

    state_e              r_state;
    logic                r_ret_q;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_go;
    logic                r_busy;
    logic [MEM_AW-1:0]   r_abase, r_bbase, r_cbase;
    logic [DIM_BITS-1:0] r_astride, r_bstride, r_cstride;
    logic [DIM_BITS-1:0] r_arows, r_acols, r_bcols;
    logic                r_done_valid;
    logic [ID_W-1:0]     r_done_id;
    logic                r_done_skip;
    logic [CNT_W-1:0]    r_done_cycles;

    always_comb begin
        w_din = '0;
        w_din[O_ID +: W_ID] = bus.cmd_id;
        w_din[O_AB +: W_AD] = bus.cmd_abase;
        w_din[O_BB +: W_AD] = bus.cmd_bbase;
        w_din[O_CB +: W_AD] = bus.cmd_cbase;
        w_din[O_AS +: W_DM] = bus.cmd_astride;
        w_din[O_BS +: W_DM] = bus.cmd_bstride;
        w_din[O_CS +: W_DM] = bus.cmd_cstride;
        w_din[O_AR +: W_DM] = bus.cmd_arows;
        w_din[O_AC +: W_DM] = bus.cmd_acols;
        w_din[O_BC +: W_DM] = bus.cmd_bcols;
    end

    assign w_push = bus.cmd_valid & ~w_full;
    // Launch is held off while the engine still reports ret from the last job.
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & ~bus.eng_ret;

    assign w_zero_dim = (w_dout[O_AR +: W_DM] == '0) |
                        (w_dout[O_AC +: W_DM] == '0) |
                        (w_dout[O_BC +: W_DM] == '0);
    assign w_ret_rise = bus.eng_ret & ~r_ret_q;

    matmul_sched_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ret_q       <= 1'b0;
            r_cnt         <= '0;
            r_go          <= 1'b0;
            r_busy        <= 1'b0;
            r_abase       <= '0;
            r_bbase       <= '0;
            r_cbase       <= '0;
            r_astride     <= '0;
            r_bstride     <= '0;
            r_cstride     <= '0;
            r_arows       <= '0;
            r_acols       <= '0;
            r_bcols       <= '0;
            r_done_valid  <= 1'b0;
            r_done_id     <= '0;
            r_done_skip   <= 1'b0;
            r_done_cycles <= '0;
        end else begin
            r_ret_q <= bus.eng_ret;
            r_go    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_abase   <= w_dout[O_AB +: W_AD];
                        r_bbase   <= w_dout[O_BB +: W_AD];
                        r_cbase   <= w_dout[O_CB +: W_AD];
                        r_astride <= w_dout[O_AS +: W_DM];
                        r_bstride <= w_dout[O_BS +: W_DM];
                        r_cstride <= w_dout[O_CS +: W_DM];
                        r_arows   <= w_dout[O_AR +: W_DM];
                        r_acols   <= w_dout[O_AC +: W_DM];
                        r_bcols   <= w_dout[O_BC +: W_DM];
                        r_done_id <= w_dout[O_ID +: W_ID];
                        r_busy    <= 1'b1;
                        if (w_zero_dim) begin
                            r_state       <= ST_CPL;
                            r_done_valid  <= 1'b1;
                            r_done_skip   <= 1'b1;
                            r_done_cycles <= '0;
                        end else begin
                            r_state <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_go    <= 1'b1;
                    r_cnt   <= CNT_W'(1);
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
                    if (w_ret_rise) begin
                        r_state       <= ST_CPL;
                        r_done_valid  <= 1'b1;
                        r_done_skip   <= 1'b0;
                        r_done_cycles <= r_cnt;
                    end
                end
                ST_CPL: begin
                    if (bus.done_ready) begin
                        r_state      <= ST_IDLE;
                        r_done_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = ~w_full;
    assign bus.eng_go      = r_go;
    assign bus.eng_abase   = r_abase;
    assign bus.eng_bbase   = r_bbase;
    assign bus.eng_cbase   = r_cbase;
    assign bus.eng_astride = r_astride;
    assign bus.eng_bstride = r_bstride;
    assign bus.eng_cstride = r_cstride;
    assign bus.eng_arows   = r_arows;
    assign bus.eng_acols   = r_acols;
    assign bus.eng_bcols   = r_bcols;
    assign bus.done_valid  = r_done_valid;
    assign bus.done_id     = r_done_id;
    assign bus.done_skip   = r_done_skip;
    assign bus.done_cycles = r_done_cycles;
    assign bus.busy        = r_busy;
    assign bus.fifo_level  = w_level;
endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: a table of single jobs followed by
// hand-written sequences for queue-full, completion stall, reset and ret hold.
module tb_matmul_sched;
    localparam int MEM_AW   = 16;
    localparam int DIM_BITS = 16;
    localparam int DEPTH    = 4;
    localparam int ID_W     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_sched_if #(.MEM_AW(MEM_AW), .DIM_BITS(DIM_BITS), .DEPTH(DEPTH), .ID_W(ID_W)) bus ();

    matmul_sched #(.MEM_AW(MEM_AW), .DIM_BITS(DIM_BITS), .DEPTH(DEPTH), .ID_W(ID_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int go_cnt = 0;
    logic [ID_W-1:0] done_q[$];

    // go pulses and accepted completions, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && bus.eng_go) go_cnt++;
        if (rst_n && bus.done_valid && bus.done_ready) done_q.push_back(bus.done_id);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    typedef struct {
        logic [ID_W-1:0]     id;
        logic [DIM_BITS-1:0] ar, ac, bc;
        int                  lat;
        logic                skip;
        logic [31:0]         cyc;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [ID_W-1:0] id, input logic [DIM_BITS-1:0] ar,
                           input logic [DIM_BITS-1:0] ac, input logic [DIM_BITS-1:0] bc);
        bus.cmd_id      = id;
        bus.cmd_abase   = 16'h1000 + 16'(id);
        bus.cmd_bbase   = 16'h2000 + 16'(id);
        bus.cmd_cbase   = 16'h3000 + 16'(id);
        bus.cmd_astride = 16'h0100 + 16'(id);
        bus.cmd_bstride = 16'h0200 + 16'(id);
        bus.cmd_cstride = 16'h0300 + 16'(id);
        bus.cmd_arows   = ar;
        bus.cmd_acols   = ac;
        bus.cmd_bcols   = bc;
    endtask

    task automatic push_job(input logic [ID_W-1:0] id, input logic [DIM_BITS-1:0] ar,
                            input logic [DIM_BITS-1:0] ac, input logic [DIM_BITS-1:0] bc);
        set_cmd(id, ar, ac, bc);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready) break;
            tick();
        end
        check("push_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_go(input int max, output int lat);
        lat = 0;
        while (!bus.eng_go && lat < max) begin
            tick();
            lat++;
        end
        check("go_seen", bus.eng_go, 1);
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = 0;
        while (!bus.done_valid && lat < max) begin
            tick();
            lat++;
        end
        check("done_seen", bus.done_valid, 1);
    endtask

    // Called in the go cycle; ret appears in cycle 'lat' counting the go cycle as 1.
    task automatic engine(input int lat, input int hold);
        repeat (lat - 1) tick();
        bus.eng_ret = 1'b1;
        repeat (hold) tick();
        bus.eng_ret = 1'b0;
    endtask

    initial begin
        int l, g0, q0;

        vt[0] = '{id: 4'd3,  ar: 16'd2, ac: 16'd2, bc: 16'd2, lat: 20, skip: 1'b0, cyc: 32'd20};
        vt[1] = '{id: 4'd5,  ar: 16'd0, ac: 16'd3, bc: 16'd3, lat: 0,  skip: 1'b1, cyc: 32'd0};
        vt[2] = '{id: 4'd7,  ar: 16'd1, ac: 16'd1, bc: 16'd1, lat: 1,  skip: 1'b0, cyc: 32'd1};
        vt[3] = '{id: 4'd9,  ar: 16'd4, ac: 16'd0, bc: 16'd5, lat: 0,  skip: 1'b1, cyc: 32'd0};
        vt[4] = '{id: 4'd12, ar: 16'd3, ac: 16'd4, bc: 16'd0, lat: 0,  skip: 1'b1, cyc: 32'd0};
        vt[5] = '{id: 4'd15, ar: 16'd8, ac: 16'd8, bc: 16'd8, lat: 5,  skip: 1'b0, cyc: 32'd5};

        bus.cmd_valid  = 1'b0;
        bus.eng_ret    = 1'b0;
        bus.done_ready = 1'b1;
        set_cmd('0, '0, '0, '0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_eng_go", bus.eng_go, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done_valid", bus.done_valid, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_done_cycles", bus.done_cycles, 0);
        check("rst_eng_abase", bus.eng_abase, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", bus.cmd_ready, 1);

        // single jobs, each into an empty FIFO while idle
        for (int i = 0; i < 6; i++) begin
            g0 = go_cnt;
            q0 = done_q.size();
            push_job(vt[i].id, vt[i].ar, vt[i].ac, vt[i].bc);
            if (vt[i].skip) begin
                wait_done(5, l);
                check("skip_lat", l, 1);
            end else begin
                wait_go(10, l);
                check("go_lat", l, 2);
                check("eng_abase", bus.eng_abase, 16'h1000 + 16'(vt[i].id));
                check("eng_cbase", bus.eng_cbase, 16'h3000 + 16'(vt[i].id));
                check("eng_bstride", bus.eng_bstride, 16'h0200 + 16'(vt[i].id));
                check("eng_arows", bus.eng_arows, vt[i].ar);
                check("eng_bcols", bus.eng_bcols, vt[i].bc);
                engine(vt[i].lat, 1);
                wait_done(40, l);
                check("eng_abase_held", bus.eng_abase, 16'h1000 + 16'(vt[i].id));
            end
            check("done_id", bus.done_id, vt[i].id);
            check("done_skip", bus.done_skip, vt[i].skip);
            check("done_cycles", bus.done_cycles, vt[i].cyc);
            check("busy_cpl", bus.busy, 1);
            tick();
            check("busy_idle", bus.busy, 0);
            check("go_pulses", go_cnt - g0, vt[i].skip ? 0 : 1);
            check("cpl_count", done_q.size() - q0, 1);
        end

        // five back-to-back pushes while the engine is busy
        g0 = go_cnt;
        q0 = done_q.size();
        push_job(4'd1, 16'd2, 16'd2, 16'd2);
        wait_go(10, l);
        for (int k = 0; k < 4; k++) begin
            set_cmd(ID_W'(2 + k), 16'd1, 16'd1, 16'd1);
            bus.cmd_valid = 1'b1;
            check("fill_ready", bus.cmd_ready, 1);
            tick();
        end
        set_cmd(4'd6, 16'd1, 16'd1, 16'd1);
        check("full_ready", bus.cmd_ready, 0);
        check("full_level", bus.fifo_level, 4);
        tick();
        tick();
        check("full_level_hold", bus.fifo_level, 4);
        bus.eng_ret = 1'b1;
        tick();
        bus.eng_ret = 1'b0;
        wait_done(5, l);
        check("full_first_id", bus.done_id, 1);
        tick();
        push_job(4'd6, 16'd1, 16'd1, 16'd1);
        for (int k = 0; k < 5; k++) begin
            wait_go(10, l);
            engine(2, 1);
            wait_done(10, l);
            tick();
        end
        check("order_count", done_q.size() - q0, 6);
        for (int k = 0; k < 6; k++) check("order_id", done_q[q0 + k], k + 1);
        check("order_go", go_cnt - g0, 6);

        // completion stalled by done_ready with a second job queued
        bus.done_ready = 1'b0;
        g0 = go_cnt;
        q0 = done_q.size();
        push_job(4'd10, 16'd3, 16'd3, 16'd3);
        push_job(4'd11, 16'd1, 16'd2, 16'd3);
        wait_go(10, l);
        engine(6, 1);
        wait_done(10, l);
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", bus.done_valid, 1);
            check("stall_id", bus.done_id, 10);
            check("stall_cycles", bus.done_cycles, 6);
            check("stall_skip", bus.done_skip, 0);
            tick();
        end
        check("stall_no_go", go_cnt - g0, 1);
        check("stall_level", bus.fifo_level, 1);
        bus.done_ready = 1'b1;
        tick();
        wait_go(10, l);
        check("go_after_accept", l, 2);
        engine(2, 1);
        wait_done(10, l);
        check("stall_second_id", bus.done_id, 11);
        tick();
        check("stall_cpl_count", done_q.size() - q0, 2);
        check("stall_first", done_q[q0], 10);

        // ret held high across the return to idle
        g0 = go_cnt;
        q0 = done_q.size();
        push_job(4'd12, 16'd2, 16'd2, 16'd2);
        wait_go(10, l);
        tick();
        tick();
        bus.eng_ret = 1'b1;
        push_job(4'd13, 16'd1, 16'd1, 16'd1);
        check("hold_done_id", bus.done_id, 12);
        check("hold_done_cycles", bus.done_cycles, 3);
        tick();
        tick();
        tick();
        check("hold_one_cpl", done_q.size() - q0, 1);
        check("hold_no_go", go_cnt - g0, 1);
        check("hold_idle", bus.busy, 0);
        check("hold_level", bus.fifo_level, 1);
        bus.eng_ret = 1'b0;
        wait_go(10, l);
        check("hold_go_lat", l, 2);
        engine(2, 1);
        wait_done(10, l);
        check("hold_second_id", bus.done_id, 13);
        tick();
        check("hold_cpl_count", done_q.size() - q0, 2);

        // reset while running with two jobs queued
        g0 = go_cnt;
        q0 = done_q.size();
        push_job(4'd4, 16'd2, 16'd2, 16'd2);
        wait_go(10, l);
        push_job(4'd5, 16'd2, 16'd2, 16'd2);
        push_job(4'd6, 16'd2, 16'd2, 16'd2);
        check("rr_level", bus.fifo_level, 2);
        check("rr_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("rr_busy0", bus.busy, 0);
        check("rr_level0", bus.fifo_level, 0);
        check("rr_go0", bus.eng_go, 0);
        check("rr_valid0", bus.done_valid, 0);
        check("rr_arows0", bus.eng_arows, 0);
        check("rr_id0", bus.done_id, 0);
        check("rr_ready", bus.cmd_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.eng_ret = 1'b1;
        tick();
        bus.eng_ret = 1'b0;
        repeat (20) tick();
        check("rr_no_cpl", done_q.size() - q0, 0);
        check("rr_go_count", go_cnt - g0, 1);
        check("rr_busy_after", bus.busy, 0);
        check("rr_level_after", bus.fifo_level, 0);
        check("rr_valid_after", bus.done_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 SHALL have parameter MEM_AW, default 16: address width of base fields.
REQ-002 SHALL have parameter DIM_BITS, default 16: width of stride and dimension fields.
REQ-003 SHALL have parameter DEPTH, default 4: job FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter ID_W, default 4: job tag width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): job-submit handshake.
REQ-008 SHALL have port cmd_id, input, ID_W: job tag.
REQ-009 SHALL have ports cmd_abase, cmd_bbase and cmd_cbase, input, MEM_AW each: matrix base addresses.
REQ-010 SHALL have ports cmd_astride, cmd_bstride, cmd_cstride, cmd_arows, cmd_acols and cmd_bcols, input, DIM_BITS each: strides and dimensions.
REQ-011 SHALL have port eng_go, output, 1: single-cycle start pulse to the matmul engine.
REQ-012 SHALL have ports eng_abase..eng_bcols, output, same widths as the cmd_* fields: engine parameters.
REQ-013 SHALL have port eng_ret, input, 1: engine completion level.
REQ-014 SHALL have ports done_valid (output, 1) and done_ready (input, 1): completion handshake.
REQ-015 SHALL have ports done_id (output, ID_W), done_skip (output, 1) and done_cycles (output, 32): completion record.
REQ-016 SHALL have ports busy (output, 1) and fifo_level (output, clog2(DEPTH+1)): status.

Function
REQ-017 SHALL queue jobs in a DEPTH-entry FIFO; cmd_ready = not full; a push occurs on cmd_valid & cmd_ready; there is no bypass path.
REQ-018 SHALL implement the states IDLE, LAUNCH, RUN and CPL.
REQ-019 In IDLE, when the FIFO is non-empty and eng_ret==0, SHALL pop the head into the job register in that cycle.
REQ-020 On that pop, SHALL go to CPL with done_skip=1 and done_cycles=0 if arows, acols or bcols is 0; otherwise SHALL go to LAUNCH.
REQ-021 In LAUNCH, eng_go SHALL be 1 for exactly one cycle and the FSM SHALL then go to RUN with the cycle counter set to 1.
REQ-022 eng_* parameters SHALL come from the job register, be registered outputs, and stay stable from the pop until the FSM leaves RUN.
REQ-023 In RUN, the cycle counter SHALL increment every cycle and saturate at 0xFFFFFFFF.
REQ-024 In RUN, on a rising edge of eng_ret (eng_ret=1 and registered previous eng_ret=0), the FSM SHALL go to CPL with done_skip=0 and done_cycles equal to the counter value.
REQ-025 An eng_ret edge outside RUN SHALL be ignored.
REQ-026 In CPL, done_valid SHALL be 1 with done_* held stable; on done_ready the FSM SHALL go to IDLE.
REQ-027 While done_ready stays low, no further job SHALL be launched.
REQ-028 busy SHALL be 1 in every state other than IDLE.
REQ-029 fifo_level SHALL equal the occupancy after the edge, counting simultaneous push and pop as net 0.
REQ-030 Latency: a job pushed into an empty FIFO while IDLE at edge t SHALL be popped at edge t+1, and eng_go SHALL be high in the cycle following edge t+2.
REQ-031 If eng_ret is still high on return to IDLE (the engine holds ret for 2 cycles), launch SHALL wait until it is 0.

Reset
REQ-032 While rst_n=0, the FSM SHALL be IDLE, the FIFO empty, previous eng_ret 0, the counter 0, and all outputs 0 except cmd_ready.
REQ-033 cmd_ready SHALL be 1 after reset release.
REQ-034 Reset mid-job SHALL discard all queued and running jobs without producing a completion record.

Structure
REQ-035 Package matmul_sched_pkg SHALL hold the state encoding, the job descriptor field widths/offsets and the packed descriptor width constant.
REQ-036 The FIFO SHALL be the sub-module matmul_sched_fifo (synchronous, DEPTH/width parameterised, registered full/empty/level).

Verification
REQ-037 One job (id 3, 2x2x2) pushed at cycle 0 with a behavioural engine asserting ret 20 cycles after go -> eng_go is a single pulse; done_id=3, done_skip=0, done_cycles=20.
REQ-038 Five jobs pushed back-to-back with DEPTH=4 and the engine busy -> cmd_ready falls after the fourth push, fifo_level reads 4, and completion order equals push order.
REQ-039 Job with arows=0 -> no eng_go; done_skip=1, done_cycles=0 within 2 cycles of the pop.
REQ-040 done_ready held low for 10 cycles with a second job queued -> done fields stable, no eng_go until the cycle after acceptance plus eng_ret low.
REQ-041 rst_n pulsed low during RUN with 2 jobs queued -> all outputs 0, fifo_level 0, and no completion record after release.
REQ-042 Engine ret held high for 2 cycles and then a new job queued -> exactly one completion, and the next eng_go only after eng_ret returns to 0.
